// File: rtl/tile_rw_pkg.sv
// Shared definitions for the tile token stream.
// Used by both the write source and the read sink.
package tile_rw_pkg;

  localparam int TOKEN_W = 17;

  localparam logic [TOKEN_W-1:0] DONE_TOKEN =
    17'h10100;

  // x^16 + x^14 + x^13 + x^11, right-shift Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FULL,
    DONE
  } state_t;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0);
  endfunction

endpackage

// File: rtl/tile_read_if.sv
// Valid/ready token stream between tile source and sink.
// Source drives data/valid, sink drives ready.
interface tile_read_if
  import tile_rw_pkg::*;
#(
  parameter int W = TOKEN_W
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/bp_lfsr.sv
// 16-bit Galois LFSR for backpressure generation.
// Seed loads on flush; advances only while enabled.
module bp_lfsr
  import tile_rw_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        flush,
  input  logic        en,
  output logic [15:0] word,
  output logic [15:0] nxt
);

  assign nxt = lfsr_step(word);

  // Seed on flush, step when enabled
  always_ff @(posedge clk) begin
    if (flush) begin
      word <= SEED;
    end else if (en) begin
      word <= nxt;
    end
  end

endmodule

// File: rtl/tile_read.sv
// Token stream sink: captures tokens, counts done tokens,
// applies LFSR backpressure and offers synchronous readback.
module tile_read #(
  parameter int DATA_W = tile_rw_pkg::TOKEN_W,
  parameter int DEPTH = 2048,
  parameter int ADDR_W = 11,
  parameter logic [DATA_W-1:0] DONE_TOKEN =
    tile_rw_pkg::DONE_TOKEN,
  parameter int TX_NUM = 1,
  parameter int BP_SHIFT = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              flush,
  tile_read_if.slave        s,
  output logic              done,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  import tile_rw_pkg::*;

  localparam int DL_W =
    (TX_NUM < 2) ? 1 : $clog2(TX_NUM + 1);

  localparam logic [15:0] MASK =
    16'(32'd3 << BP_SHIFT);

  localparam logic [ADDR_W:0] LAST_CNT =
    (ADDR_W+1)'(DEPTH - 1);

  localparam logic [ADDR_W:0] CNT_ONE =
    (ADDR_W+1)'(1);

  localparam logic [DL_W-1:0] DL_ONE = DL_W'(1);

  state_t            state;
  state_t            state_d;
  logic              ready_q;
  logic              ready_d;
  logic [ADDR_W:0]   cnt;
  logic [DL_W-1:0]   done_left;
  logic              ovf;
  logic [DATA_W-1:0] rd_q;
  logic [15:0]       lfsr_word;
  logic [15:0]       lfsr_nxt;
  logic              lfsr_en;
  logic              xfer;
  logic              is_done_tok;
  logic              last_tok;
  logic              fill;
  logic              ok_now;
  logic              ok_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  bp_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .flush(flush),
    .en   (lfsr_en),
    .word (lfsr_word),
    .nxt  (lfsr_nxt)
  );

  assign lfsr_en = (state == RECV);

  assign xfer =
    s.valid & ready_q & (state == RECV);

  assign is_done_tok = (s.data == DONE_TOKEN);

  assign last_tok =
    xfer & is_done_tok & (done_left == DL_ONE);

  assign fill = xfer & (cnt == LAST_CNT);

  // ready tracks the mask of the LFSR word it will sit beside
  assign ok_now =
    !bp_en || ((lfsr_word & MASK) == 16'h0);

  assign ok_nxt =
    !bp_en || ((lfsr_nxt & MASK) == 16'h0);

  // Next state and next registered ready
  always_comb begin
    state_d = state;
    ready_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (TX_NUM == 0) begin
          state_d = DONE;
        end else begin
          state_d = RECV;
          ready_d = ok_now;
        end
      end
      RECV: begin
        if (last_tok) begin
          state_d = DONE;
        end else if (fill) begin
          state_d = FULL;
        end else begin
          ready_d = ok_nxt;
        end
      end
      FULL: state_d = FULL;
      DONE: state_d = DONE;
    endcase
  end

  // Control state, counters and sticky flags
  always_ff @(posedge clk) begin
    if (flush) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      cnt       <= '0;
      done_left <= DL_W'(TX_NUM);
      ovf       <= 1'b0;
    end else begin
      state   <= state_d;
      ready_q <= ready_d;
      if (xfer) begin
        cnt <= cnt + CNT_ONE;
      end
      if (xfer && is_done_tok &&
          done_left != '0) begin
        done_left <= done_left - DL_ONE;
      end
      if (state == FULL && s.valid) begin
        ovf <= 1'b1;
      end
    end
  end

  // Capture memory write; contents survive flush
  always_ff @(posedge clk) begin
    if (!flush && xfer) begin
      mem[cnt[ADDR_W-1:0]] <= s.data;
    end
  end

  // Registered readback, old data on same-address write
  always_ff @(posedge clk) begin
    if (flush) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[rd_addr];
    end
  end

  assign s.ready  = ready_q;
  assign done     = (state == DONE);
  assign count    = cnt;
  assign overflow = ovf;
  assign rd_data  = rd_q;

endmodule

// File: tb/tb_tile_read.sv
// Directed bench for tile_read: plain stream, LFSR
// backpressure, multi-done, fill/overflow, flush, readback.
module tb_tile_read;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        flush;
  logic        bp_en;
  logic [10:0] rd_addr;
  logic [16:0] rd_data;
  logic        done;
  logic        overflow;
  logic [11:0] count;

  logic        flush2;
  logic        bp_en2;
  logic [10:0] rd_addr2;
  logic [16:0] rd_data2;
  logic        done2;
  logic        overflow2;
  logic [11:0] count2;

  tile_read_if #(.W(17)) bus ();
  tile_read_if #(.W(17)) bus2 ();

  tile_read u_dut (
    .clk     (clk),
    .flush   (flush),
    .s       (bus),
    .done    (done),
    .bp_en   (bp_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .count   (count),
    .overflow(overflow)
  );

  tile_read #(
    .TX_NUM(2)
  ) u_dut2 (
    .clk     (clk),
    .flush   (flush2),
    .s       (bus2),
    .done    (done2),
    .bp_en   (bp_en2),
    .rd_addr (rd_addr2),
    .rd_data (rd_data2),
    .count   (count2),
    .overflow(overflow2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // independent model: shift right, feedback into 15,13,12,10
  function automatic logic [15:0] mstep(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic fb;
    fb = v[0];
    r = {fb, v[15:1]};
    r[13] = r[13] ^ fb;
    r[12] = r[12] ^ fb;
    r[10] = r[10] ^ fb;
    return r;
  endfunction

  function automatic logic [16:0] bp_tok(input int i);
    if (i == 63) return 17'h10100;
    return 17'(i + 1);
  endfunction

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    bus.valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic rb(
    input int          a,
    input logic [16:0] e,
    input string       tag
  );
    rd_addr = a[10:0];
    @(negedge clk);
    chk(tag, 32'(rd_data), 32'(e));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] t1 [3];
    logic [16:0] rbx [5];
    logic [15:0] m;
    logic        rdy;
    int          n;
    int          cyc;

    t1 = '{17'h00005, 17'h00007, 17'h10100};

    flush = 1'b1;
    bp_en = 1'b0;
    rd_addr = '0;
    bus.valid = 1'b0;
    bus.data = '0;
    flush2 = 1'b1;
    bp_en2 = 1'b0;
    rd_addr2 = '0;
    bus2.valid = 1'b0;
    bus2.data = '0;
    repeat (2) @(negedge clk);

    // plain stream, no backpressure
    do_flush();
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    chk("ready_after_idle", 32'(bus.ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      bus.valid = 1'b1;
      bus.data = t1[i];
      @(negedge clk);
      if (i == 1) begin
        chk("t1_mid_done", 32'(done), 32'd0);
        chk("t1_mid_count", 32'(count), 32'd2);
      end
    end
    bus.data = 17'h00055;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_ready_low", 32'(bus.ready), 32'd0);
    chk("t1_count", 32'(count), 32'd3);
    repeat (2) @(negedge clk);
    chk("t1_done_no_ovf", 32'(overflow), 32'd0);
    chk("t1_done_count", 32'(count), 32'd3);
    chk("t1_done_held", 32'(done), 32'd1);
    bus.valid = 1'b0;
    rb(0, 17'h00005, "t1_rb0");
    rb(1, 17'h00007, "t1_rb1");
    rb(2, 17'h10100, "t1_rb2");

    // LFSR backpressure, 64 tokens
    bp_en = 1'b1;
    do_flush();
    chk("bp_done_cleared", 32'(done), 32'd0);
    @(negedge clk);
    m = 16'hACE1;
    n = 0;
    cyc = 0;
    while (n < 64 && cyc < 2000) begin
      chk("bp_ready", 32'(bus.ready),
          32'(m[1:0] == 2'b00));
      bus.valid = 1'b1;
      bus.data = bp_tok(n);
      rdy = bus.ready;
      @(posedge clk);
      if (rdy) n++;
      m = mstep(m);
      cyc++;
      @(negedge clk);
    end
    bus.valid = 1'b0;
    chk("bp_sent", 32'(n), 32'd64);
    chk("bp_count", 32'(count), 32'd64);
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_ready_low", 32'(bus.ready), 32'd0);
    bp_en = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rb(i, bp_tok(i), "bp_rb");
    end

    // two done tokens required
    flush2 = 1'b0;
    @(negedge clk);
    chk("tx2_ready", 32'(bus2.ready), 32'd1);
    for (int i = 0; i < 21; i++) begin
      bus2.valid = 1'b1;
      bus2.data = (i == 10 || i == 20) ?
        17'h10100 : 17'(32'h100 + i);
      @(negedge clk);
      if (i == 10) begin
        chk("tx2_mid_done", 32'(done2), 32'd0);
        chk("tx2_mid_count", 32'(count2), 32'd11);
      end
    end
    bus2.valid = 1'b0;
    chk("tx2_done", 32'(done2), 32'd1);
    chk("tx2_count", 32'(count2), 32'd21);
    chk("tx2_ready_low", 32'(bus2.ready), 32'd0);
    chk("tx2_ovf", 32'(overflow2), 32'd0);

    // fill memory and hold valid
    do_flush();
    @(negedge clk);
    n = 0;
    for (int c = 0; c < 2060; c++) begin
      bus.valid = 1'b1;
      bus.data = 17'(n);
      rdy = bus.ready;
      @(negedge clk);
      if (rdy) n++;
    end
    bus.valid = 1'b0;
    chk("full_sent", 32'(n), 32'd2048);
    chk("full_count", 32'(count), 32'd2048);
    chk("full_ready", 32'(bus.ready), 32'd0);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_done", 32'(done), 32'd0);
    rb(0, 17'd0, "full_rb0");
    rb(2047, 17'd2047, "full_rb2047");

    // flush in the middle of a stream
    do_flush();
    chk("fl_ovf_cleared", 32'(overflow), 32'd0);
    chk("fl_count0", 32'(count), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.valid = 1'b1;
      bus.data = 17'(32'h0A0 + i);
      @(negedge clk);
    end
    chk("fl_count5", 32'(count), 32'd5);
    bus.data = 17'h000A5;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.valid = 1'b0;
    chk("fl_discard", 32'(count), 32'd0);
    @(negedge clk);
    rd_addr = 11'd0;
    bus.valid = 1'b1;
    bus.data = 17'h000B0;
    @(negedge clk);
    chk("rw_same_addr", 32'(rd_data), 32'h0A0);
    bus.data = 17'h000B1;
    @(negedge clk);
    bus.data = 17'h000B2;
    @(negedge clk);
    bus.valid = 1'b0;
    chk("fl_count3", 32'(count), 32'd3);
    chk("fl_done", 32'(done), 32'd0);
    chk("fl_ovf", 32'(overflow), 32'd0);

    // readback stepping one address per cycle
    rbx = '{17'h0B0, 17'h0B1, 17'h0B2,
            17'h0A3, 17'h0A4};
    for (int a = 0; a < 5; a++) begin
      rd_addr = 11'(a);
      @(negedge clk);
      chk("step_rb", 32'(rd_data), 32'(rbx[a]));
    end
    chk("step_ready", 32'(bus.ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_read.md
Name: tile_read

Overview:
- Receiving end of the 17-bit valid/ready token stream produced by the tile write source.
- Accepts tokens under a programmable backpressure pattern and stores them in a local capture memory.
- Counts stream-terminating done tokens (17'h10100) and asserts done once the expected number has arrived.
- Provides a synchronous readback port so a bench or host can compare captured data against the golden file.

Parameters:
- DATA_W, 17, token width (bit 16 flags control tokens).
- DEPTH, 2048, capture memory entries.
- ADDR_W, 11, log2(DEPTH).
- DONE_TOKEN, 17'h10100, token value that terminates one transaction.
- TX_NUM, 1, number of done tokens expected before done asserts.
- BP_SHIFT, 0, left shift applied to the 2-bit backpressure mask (mask = 3 << BP_SHIFT).
- LFSR_SEED, 16'hACE1, nonzero reset seed for the backpressure LFSR.

Ports:
- clk  input  1  clock; all logic on posedge.
- flush  input  1  synchronous, active-high reset.
- data  input  DATA_W  token from the upstream source.
- valid  input  1  upstream token valid.
- ready  output  1  sink can accept (registered).
- done  output  1  TX_NUM done tokens received; sticky until flush.
- bp_en  input  1  1 = pseudo-random backpressure; 0 = ready whenever receiving.
- rd_addr  input  ADDR_W  capture memory readback address.
- rd_data  output  DATA_W  mem[rd_addr], one cycle after rd_addr.
- count  output  ADDR_W+1  tokens accepted since flush.
- overflow  output  1  valid seen while memory full; sticky until flush.

Behaviour:
- Reset (flush=1 at posedge):
  - ready=0, done=0, count=0, overflow=0, rd_data=0.
  - State IDLE, LFSR=LFSR_SEED, done_left=TX_NUM.
  - Memory contents are not cleared.
- A transfer occurs on a posedge with valid && ready. On a transfer:
  - mem[count] <= data; count <= count+1.
  - If data==DONE_TOKEN, done_left decrements.
  - A transfer is never accepted with ready=0.
- States:
  - IDLE: ready=0. Next cycle -> RECV. IDLE lasts exactly one cycle after flush deasserts.
  - RECV: LFSR (x^16+x^14+x^13+x^11, Galois) advances every cycle. ready_next = bp_en ? ((lfsr & mask)==0) : 1.
  - RECV -> DONE when a transfer carries the final done token (done_left 1->0). done=1 and ready=0 on the very next cycle; ready_next is suppressed in the same cycle as that transfer.
  - RECV -> FULL when a transfer makes count==DEPTH. ready=0 next cycle.
  - FULL: ready=0. overflow<=1 on any cycle with valid=1. Leaves only via flush.
  - DONE: ready=0, done=1 held. Further valid is ignored and does not set overflow. Leaves only via flush.
- Simultaneous final-done-token and count==DEPTH: DONE wins, overflow stays 0.
- TX_NUM=0: DONE is entered directly from IDLE; no tokens are accepted.
- Readback: rd_data registered from mem[rd_addr], 1-cycle latency, valid in every state. Read and write of the same address in one cycle returns the old data.
- count saturates naturally at DEPTH; it needs width ADDR_W+1.
- Flush mid-transfer: a valid&&ready in the flush cycle is discarded (no write, no count).

Decomposition:
- Package tile_rw_pkg holds:
  - TOKEN_W=17.
  - DONE_TOKEN=17'h10100.
  - state enum {IDLE, RECV, FULL, DONE}.
  - LFSR tap constant.
- The package is shared with the write-side block.
- One sub-module, bp_lfsr: 16-bit Galois LFSR with seed load on flush and enable input, producing the random word.
- Capture memory is an inferred array inside tile_read.

Test Plan:
- bp_en=0, TX_NUM=1, source sends 0x00005, 0x00007, 0x10100 back-to-back:
  - ready=1 from the 2nd cycle after flush falls.
  - count=3; done=1 one cycle after the 0x10100 transfer; ready=0 the same cycle.
  - Readback of addr 0..2 returns 5, 7, 0x10100.
- bp_en=1, BP_SHIFT=0, 64-token stream ending in DONE_TOKEN:
  - ready toggles per the LFSR from seed 0xACE1.
  - All 64 tokens captured in order, no duplicates, count=64.
- TX_NUM=2, stream with an embedded 0x10100 at index 10 and a final one at index 20:
  - done stays 0 after index 10.
  - done=1 after index 20, count=21.
- DEPTH=2048, 2049 non-done tokens:
  - ready=0 after the 2048th transfer, count=2048.
  - overflow=1 when valid is held; done=0.
- Flush asserted mid-stream after 5 tokens, then a 3-token stream:
  - count returns to 0, then reaches 3; done and overflow are cleared.
  - mem[3..4] retain stale pre-flush data.
- Readback timing: rd_addr stepped 0..3 each cycle during RECV; rd_data matches mem[rd_addr] one cycle later.
